// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared state encoding and default sizing for the
// adder arbitration controller (adder_arb_ctrl and adder_rr_arb).
`timescale 1ns/1ps
package adder_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int OP_CNT_W    = 16;

endpackage

// File: rtl/adder_rr_arb.sv
// adder_rr_arb: combinational round-robin picker. Grants the first active
// request at or after the pointer, wrapping past the top requester.
`timescale 1ns/1ps
module adder_rr_arb
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    logic w_found;
    int   w_pos;

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/adder_arb_ctrl.sv
// adder_arb_ctrl: shares one registered adder among NUM_REQ requesters.
// Sequence per operation: IDLE (grant) -> ISSUE -> WAIT -> RESP.
// Optional build macro ADDER_ARB_CTRL_STATS_EN adds a saturating op_count.
`timescale 1ns/1ps
module adder_arb_ctrl
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       add_enable,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH:0]             add_sum,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH:0]             rsp_sum
`ifdef ADDER_ARB_CTRL_STATS_EN
    ,
    output logic [OP_CNT_W-1:0]        op_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic [WIDTH:0]     r_rsp_sum;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_any;
    logic               w_grant;
    logic               w_rsp_hs;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;

    adder_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx)
    );

    assign w_any   = |w_gnt;
    assign w_sel_a = req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
    assign w_sel_b = req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];

    assign add_a   = r_add_a;
    assign add_b   = r_add_b;
    assign rsp_id  = r_idx;
    assign rsp_sum = r_rsp_sum;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-driven outputs; the grant is qualified by
    // rst so req_ready reads low while reset is held even though we sit in IDLE.
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_rsp_hs   = 1'b0;
        req_ready  = '0;
        add_enable = 1'b0;
        rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && rst) begin
                    req_ready = w_gnt;
                    w_grant   = 1'b1;
                    w_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                add_enable = 1'b1;
                w_next     = ST_WAIT;
            end
            ST_WAIT: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_hs = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch operands/owner on grant, capture the sum in WAIT, advance the pointer on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr  <= '0;
            r_idx     <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_rsp_sum <= '0;
        end else begin
            if (w_grant) begin
                r_idx   <= w_gnt_idx;
                r_add_a <= w_sel_a;
                r_add_b <= w_sel_b;
            end
            if (r_state == ST_WAIT) begin
                r_rsp_sum <= add_sum;
            end
            if (w_rsp_hs) begin
                r_rr_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

`ifdef ADDER_ARB_CTRL_STATS_EN
    logic [OP_CNT_W-1:0] r_op_count;

    // Count completed response handshakes, sticking at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_count <= '0;
        end else if (w_rsp_hs && (r_op_count != '1)) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_adder_arb_ctrl.sv
// tb_adder_arb_ctrl: table-driven vectors plus directed sequences for
// round-robin order, backpressure, mid-operation reset and (optionally)
// the ADDER_ARB_CTRL_STATS_EN counter. A scoreboard pairs grants with responses.
`timescale 1ns/1ps
module tb_adder_arb_ctrl;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        add_enable;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [4:0]  add_sum = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_sum;
`ifdef ADDER_ARB_CTRL_STATS_EN
    logic [15:0] op_count;
`endif

    always #5 clk = ~clk;

    adder_arb_ctrl #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_enable (add_enable),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum)
`ifdef ADDER_ARB_CTRL_STATS_EN
        ,
        .op_count   (op_count)
`endif
    );

    // Registered adder model: result one cycle after add_enable.
    always @(posedge clk) begin
        if (add_enable) add_sum <= {1'b0, add_a} + {1'b0, add_b};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0] id;
        logic [4:0] sum;
    } rsp_t;

    rsp_t sb_q[$];
    int   gnt_log[$];

    // Scoreboard: push on grant, pop and compare on response handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            if (req_ready != 4'b0000) begin
                check("gnt_onehot", {31'b0, $onehot(req_ready)}, 32'd1);
                check("gnt_has_req", req_valid & req_ready, req_ready);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i]) begin
                        e.id  = 2'(i);
                        e.sum = {1'b0, req_a[i*4 +: 4]} + {1'b0, req_b[i*4 +: 4]};
                        sb_q.push_back(e);
                        gnt_log.push_back(i);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_rsp: actual id=%0d sum=%0d required=none", rsp_id, rsp_sum);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_rsp_id", rsp_id, e.id);
                    check("sb_rsp_sum", rsp_sum, e.sum);
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        int          exp_id;
        logic [4:0]  exp_sum;
    } vec_t;

    vec_t vecs[7];
    int   exp_order[5];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One complete operation from an IDLE start with rsp_ready high.
    task automatic apply_vec(input vec_t v, input string tag);
        logic [3:0] ea;
        logic [3:0] eb;
        ea = v.a[v.exp_id*4 +: 4];
        eb = v.b[v.exp_id*4 +: 4];
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        #1;
        check({tag, "_req_ready"}, req_ready, 4'b0001 << v.exp_id);
        tick();
        req_valid = '0;
        #1;
        check({tag, "_issue_en"}, add_enable, 1);
        check({tag, "_issue_a"}, add_a, ea);
        check({tag, "_issue_b"}, add_b, eb);
        check({tag, "_issue_ready"}, req_ready, 0);
        tick();
        #1;
        check({tag, "_wait_en"}, add_enable, 0);
        check({tag, "_wait_valid"}, rsp_valid, 0);
        check({tag, "_wait_hold_a"}, add_a, ea);
        tick();
        #1;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_id"}, rsp_id, v.exp_id);
        check({tag, "_rsp_sum"}, rsp_sum, v.exp_sum);
        tick();
        #1;
        check({tag, "_idle_valid"}, rsp_valid, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        vec_t sv;

        vecs[0] = '{4'b0100, 16'h0900, 16'h0700, 2, 5'd16};
        vecs[1] = '{4'b1111, 16'h4321, 16'h8765, 3, 5'd12};
        vecs[2] = '{4'b1111, 16'h4321, 16'h8765, 0, 5'd6};
        vecs[3] = '{4'b0101, 16'h0A0C, 16'h0306, 2, 5'd13};
        vecs[4] = '{4'b0001, 16'h000E, 16'h0009, 0, 5'd23};
        vecs[5] = '{4'b0010, 16'h00F0, 16'h00F0, 1, 5'd30};
        vecs[6] = '{4'b1001, 16'hB00D, 16'h2004, 3, 5'd13};
        exp_order = '{0, 1, 2, 3, 0};
        sv = '{4'b0001, 16'h0003, 16'h0004, 0, 5'd7};

        rst       = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_add_enable", add_enable, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // All four requesters held valid: round-robin order from pointer 0.
        gnt_log.delete();
        req_a     = 16'h4321;
        req_b     = 16'h8765;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        waited    = 0;
        while (gnt_log.size() < 5 && waited < 40) begin
            tick();
            waited++;
        end
        req_valid = '0;
        check("rr_grant_count", gnt_log.size(), 5);
        if (gnt_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("rr_order%0d", k), gnt_log[k], exp_order[k]);
            end
        end
        repeat (6) tick();
        check("rr_sb_drained", sb_q.size(), 0);

        // Backpressure: response held while others keep requesting.
        req_a     = 16'h0050;
        req_b     = 16'h0060;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b1111;
        waited = 0;
        while (!rsp_valid && waited < 8) begin
            tick();
            waited++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 1);
            check("bp_sum", rsp_sum, 11);
            check("bp_req_ready", req_ready, 0);
            check("bp_add_enable", add_enable, 0);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        check("bp_release_valid", rsp_valid, 1);
        tick();
        #1;
        check("bp_after_valid", rsp_valid, 0);
        check("bp_after_ready", req_ready, 0);

        // Reset during WAIT aborts the operation; pointer restarts at 0.
        req_a     = 16'h0300;
        req_b     = 16'h0300;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        check("mr_pre_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1010;
        req_a     = 16'h2050;
        req_b     = 16'h1040;
        #1;
        check("mr_req_ready", req_ready, 0);
        check("mr_add_enable", add_enable, 0);
        check("mr_add_a", add_a, 0);
        check("mr_add_b", add_b, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_rsp_id", rsp_id, 0);
        check("mr_rsp_sum", rsp_sum, 0);
        sb_q.delete();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mr_first_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        waited = 0;
        while (!rsp_valid && waited < 8) begin
            tick();
            waited++;
        end
        check("mr_rsp_valid_after", rsp_valid, 1);
        check("mr_rsp_id_after", rsp_id, 1);
        check("mr_rsp_sum_after", rsp_sum, 9);
        tick();
        check("mr_sb_drained", sb_q.size(), 0);

`ifdef ADDER_ARB_CTRL_STATS_EN
        check("st_after_reset", op_count, 1);
        for (int n = 0; n < 4; n++) begin
            apply_vec(sv, $sformatf("st%0d", n));
        end
        check("st_five", op_count, 5);
        force dut.r_op_count = 16'hFFFD;
        #1;
        release dut.r_op_count;
        apply_vec(sv, "st_sat0");
        check("st_fffe", op_count, 16'hFFFE);
        apply_vec(sv, "st_sat1");
        check("st_ffff", op_count, 16'hFFFF);
        apply_vec(sv, "st_sat2");
        check("st_hold", op_count, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_arb_ctrl.md
ADDER_ARB_CTRL -- requirements
Module: adder_arb_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one adder (2..8).
REQ-002 Parameter WIDTH, default 4: operand width; sum width is WIDTH+1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-007 req_a, req_b  input  NUM_REQ*WIDTH each  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 add_enable  output  1  enable to the shared registered adder.
REQ-009 add_a, add_b  output  WIDTH each  operands to the adder.
REQ-010 add_sum  input  WIDTH+1  adder result, valid one cycle after add_enable.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  result consumer accept.
REQ-013 rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns rsp_sum.
REQ-014 rsp_sum  output  WIDTH+1  captured result.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: when any req_valid is high, grant the first valid requester at or after rr_ptr (wrapping), assert its req_ready combinationally in that cycle, latch its operands and index, then go to ISSUE; otherwise stay in IDLE.
REQ-017 req_ready is low in every state except IDLE.
REQ-018 ISSUE: add_enable=1 for exactly one cycle with the latched operands on add_a/add_b, then go to WAIT.
REQ-019 WAIT: capture add_sum into rsp_sum, then go to RESP.
REQ-020 RESP: rsp_valid=1 with rsp_id/rsp_sum held stable until rsp_valid&&rsp_ready; in that cycle set rr_ptr to (granted index+1) mod NUM_REQ and go to IDLE.
REQ-021 Latency: accept at cycle 0 gives rsp_valid at cycle 3; peak throughput is one operation per 4 cycles.
REQ-022 Outside ISSUE: add_enable=0 and add_a/add_b hold their last values.
REQ-023 Sum is full-width unsigned: max operands 15+15 give 5'd30 with no truncation.
REQ-024 A requester that deasserts req_valid before being granted loses its turn with no side effect.
REQ-025 Backpressure: rsp_ready held low keeps the FSM in RESP indefinitely, with no new grants.

Reset
REQ-026 On rst low, independent of clk: state=IDLE, rr_ptr=0, req_ready=0, add_enable=0, add_a=add_b=0, rsp_valid=0, rsp_id=0, rsp_sum=0.
REQ-027 Reset in any state aborts the in-flight operation with no response; the first grant after release starts from requester 0.

Configuration
REQ-028 Macro ADDER_ARB_CTRL_STATS_EN, when defined, adds output op_count (16 bits): it increments on each response handshake, saturates at 16'hFFFF and resets to 0.
REQ-029 Without ADDER_ARB_CTRL_STATS_EN, the op_count port and its logic are absent, and all other behaviour is identical.

Structure
REQ-030 Package adder_arb_pkg holds the FSM state enum, the default NUM_REQ/WIDTH constants and the op_count width.
REQ-031 Round-robin selection lives in sub-module adder_rr_arb: inputs are the request vector and rr_ptr; outputs are the one-hot grant and the index; it is purely combinational.

Verification
REQ-032 Single request: req 2 gets a=4'd9, b=4'd7 with rsp_ready=1 -> req_ready[2] high at cycle 0, add_enable at cycle 1, rsp_valid at cycle 3 with rsp_id=2 and rsp_sum=5'd16.
REQ-033 All four valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0, and each response returns that requester's sum.
REQ-034 Overflow width: a=4'hF, b=4'hF -> rsp_sum=5'd30.
REQ-035 Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_sum stable, req_ready stays 0, add_enable stays 0; release -> handshake, then IDLE.
REQ-036 Reset mid-operation: rst low during WAIT -> all outputs 0 immediately; after release with req 3 and req 1 valid, req 1 is granted first.
REQ-037 With ADDER_ARB_CTRL_STATS_EN defined: 5 completed operations -> op_count=5; the counter is preloaded near saturation, then holds at 16'hFFFF.
